// File: rtl/vst_pkg.sv
// Shared types and constants for the VST PAL pattern generator.
// Holds the packet type nibbles, the pattern_sel encodings and the FSM state type.
package vst_pkg;

  localparam logic [3:0]  PKT_TYPE_CTRL  = 4'hF;
  localparam logic [3:0]  PKT_TYPE_VIDEO = 4'h0;
  localparam int unsigned CTRL_BEATS     = 10;

  typedef enum logic [1:0] {
    PAT_BARS    = 2'd0,
    PAT_RAMP    = 2'd1,
    PAT_FLAT    = 2'd2,
    PAT_CHECKER = 2'd3
  } pat_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CTRL  = 2'd1,
    ST_VHDR  = 2'd2,
    ST_PIXEL = 2'd3
  } state_e;

endpackage

// File: rtl/vst_pal_pattern_gen_if.sv
// Streaming source bus of the pattern generator (ready latency 0).
// Signals: dout_data, dout_valid, dout_startofpacket, dout_endofpacket (source -> sink),
//          dout_ready (sink -> source).
// Modports: master = generator side, slave = sink side.
interface vst_pal_pattern_gen_if #(
  parameter int unsigned DATA_WIDTH = 10
);
  logic [DATA_WIDTH-1:0] dout_data;
  logic                  dout_valid;
  logic                  dout_ready;
  logic                  dout_startofpacket;
  logic                  dout_endofpacket;

  modport master (
    output dout_data, dout_valid, dout_startofpacket, dout_endofpacket,
    input  dout_ready
  );

  modport slave (
    input  dout_data, dout_valid, dout_startofpacket, dout_endofpacket,
    output dout_ready
  );
endinterface

// File: rtl/vst_pattern_pixel.sv
// Combinational pixel value for the selected test pattern.
// Ports: i_x/i_y raster position, i_bar colour-bar index (from the bar sub-counter),
//        i_mode latched pattern, o_pix_c pixel value.
module vst_pattern_pixel
  import vst_pkg::*;
#(
  parameter int unsigned           DATA_WIDTH = 10,
  parameter logic [DATA_WIDTH-1:0] FLAT_LEVEL = 10'd512
) (
  input  logic [15:0]           i_x,
  input  logic [15:0]           i_y,
  input  logic [2:0]            i_bar,
  input  pat_e                  i_mode,
  output logic [DATA_WIDTH-1:0] o_pix_c
);

  localparam longint unsigned MAX_LEVEL = (64'd1 << DATA_WIDTH) - 64'd1;

  // Eight bar levels k*(2^DATA_WIDTH-1)/7, folded to constants at elaboration.
  localparam logic [DATA_WIDTH-1:0] BAR_LVL [8] = '{
    DATA_WIDTH'((64'd0 * MAX_LEVEL) / 64'd7),
    DATA_WIDTH'((64'd1 * MAX_LEVEL) / 64'd7),
    DATA_WIDTH'((64'd2 * MAX_LEVEL) / 64'd7),
    DATA_WIDTH'((64'd3 * MAX_LEVEL) / 64'd7),
    DATA_WIDTH'((64'd4 * MAX_LEVEL) / 64'd7),
    DATA_WIDTH'((64'd5 * MAX_LEVEL) / 64'd7),
    DATA_WIDTH'((64'd6 * MAX_LEVEL) / 64'd7),
    DATA_WIDTH'((64'd7 * MAX_LEVEL) / 64'd7)
  };

  // Only bit 5 of y selects the checker phase.
  logic w_unused_y;
  assign w_unused_y = ^{i_y[15:6], i_y[4:0]};

  always_comb begin
    o_pix_c = '0;
    case (i_mode)
      PAT_BARS:    o_pix_c = BAR_LVL[i_bar];
      PAT_RAMP:    o_pix_c = DATA_WIDTH'(i_x);
      PAT_FLAT:    o_pix_c = FLAT_LEVEL;
      PAT_CHECKER: o_pix_c = (i_x[5] ^ i_y[5]) ? '1 : '0;
      default:     o_pix_c = '0;
    endcase
  end

endmodule

// File: rtl/vst_pal_pattern_gen.sv
// PAL test-pattern source: per frame an optional control packet, then a video packet
// (header beat + IM_WIDTH*IM_HEIGHT pixels) on a valid/ready stream.
// Ports: vst_clk, vst_rst (async, active high), enable (frame request),
//        pattern_sel (0 bars, 1 ramp, 2 flat, 3 checker), dout (stream master),
//        frame_cnt (completed video packets), busy (not idle).
// Macro VST_PATTERN_CTRL_PKT_EN: when defined each frame starts with a 10-beat
// control packet; otherwise frames start directly with the video header.
module vst_pal_pattern_gen
  import vst_pkg::*;
#(
  parameter int unsigned           DATA_WIDTH   = 10,
  parameter int unsigned           IM_WIDTH     = 720,
  parameter int unsigned           IM_HEIGHT    = 288,
  parameter logic [3:0]            IM_INTERLACE = 4'h0,
  parameter logic [DATA_WIDTH-1:0] FLAT_LEVEL   = 10'd512
) (
  input  logic                  vst_clk,
  input  logic                  vst_rst,
  input  logic                  enable,
  input  logic [1:0]            pattern_sel,
  vst_pal_pattern_gen_if.master dout,
  output logic [15:0]           frame_cnt,
  output logic                  busy
);

  localparam logic [15:0] X_LAST       = 16'(IM_WIDTH - 1);
  localparam logic [15:0] Y_LAST       = 16'(IM_HEIGHT - 1);
  localparam logic [15:0] BAR_LEN_LAST = 16'(IM_WIDTH / 8 - 1);

`ifdef VST_PATTERN_CTRL_PKT_EN
  localparam state_e                ST_FIRST   = ST_CTRL;
  localparam logic [DATA_WIDTH-1:0] FIRST_DATA = DATA_WIDTH'(PKT_TYPE_CTRL);
  localparam logic [15:0]           W16        = 16'(IM_WIDTH);
  localparam logic [15:0]           H16        = 16'(IM_HEIGHT);

  // Control packet payload: type, width nibbles, height nibbles, interlace.
  function automatic logic [3:0] ctrl_nibble(input logic [3:0] idx);
    case (idx)
      4'd0:    return PKT_TYPE_CTRL;
      4'd1:    return W16[15:12];
      4'd2:    return W16[11:8];
      4'd3:    return W16[7:4];
      4'd4:    return W16[3:0];
      4'd5:    return H16[15:12];
      4'd6:    return H16[11:8];
      4'd7:    return H16[7:4];
      4'd8:    return H16[3:0];
      4'd9:    return IM_INTERLACE;
      default: return 4'h0;
    endcase
  endfunction

  logic [3:0] r_cidx;
`else
  localparam state_e                ST_FIRST   = ST_VHDR;
  localparam logic [DATA_WIDTH-1:0] FIRST_DATA = DATA_WIDTH'(PKT_TYPE_VIDEO);
`endif

  state_e                r_state;
  pat_e                  r_mode;
  // x/y/bar counters point at the next pixel to be loaded into the output stage.
  logic [15:0]           r_x;
  logic [15:0]           r_y;
  logic [2:0]            r_bar;
  logic [15:0]           r_bar_cnt;
  logic [DATA_WIDTH-1:0] r_data;
  logic                  r_valid;
  logic                  r_sop;
  logic                  r_eop;
  logic                  r_busy;
  logic [15:0]           r_frame_cnt;

  logic [DATA_WIDTH-1:0] w_pix;
  logic                  w_load;
  logic                  w_pix_last;
  logic                  w_boundary;
  logic                  w_frame_done;

  vst_pattern_pixel #(
    .DATA_WIDTH (DATA_WIDTH),
    .FLAT_LEVEL (FLAT_LEVEL)
  ) u_pixel (
    .i_x     (r_x),
    .i_y     (r_y),
    .i_bar   (r_bar),
    .i_mode  (r_mode),
    .o_pix_c (w_pix)
  );

  // Output stage is free when empty or when its beat transfers this edge.
  assign w_load       = ~r_valid | dout.dout_ready;
  assign w_pix_last   = (r_x == X_LAST) && (r_y == Y_LAST);
  assign w_frame_done = (r_state == ST_PIXEL) && r_eop;
  // Frame boundary: idle, or the last pixel of a frame is leaving.
  assign w_boundary   = (r_state == ST_IDLE) || w_frame_done;

  always_ff @(posedge vst_clk or posedge vst_rst) begin
    if (vst_rst) begin
      r_state     <= ST_IDLE;
      r_mode      <= PAT_BARS;
      r_x         <= '0;
      r_y         <= '0;
      r_bar       <= '0;
      r_bar_cnt   <= '0;
      r_data      <= '0;
      r_valid     <= 1'b0;
      r_sop       <= 1'b0;
      r_eop       <= 1'b0;
      r_busy      <= 1'b0;
      r_frame_cnt <= '0;
`ifdef VST_PATTERN_CTRL_PKT_EN
      r_cidx      <= '0;
`endif
    end else if (w_load) begin
      if (w_frame_done) r_frame_cnt <= r_frame_cnt + 16'd1;
      if (w_boundary) begin
        if (enable) begin
          r_state <= ST_FIRST;
          r_mode  <= pat_e'(pattern_sel);
          r_data  <= FIRST_DATA;
          r_valid <= 1'b1;
          r_sop   <= 1'b1;
          r_eop   <= 1'b0;
          r_busy  <= 1'b1;
`ifdef VST_PATTERN_CTRL_PKT_EN
          r_cidx  <= '0;
`endif
        end else begin
          r_state <= ST_IDLE;
          r_data  <= '0;
          r_valid <= 1'b0;
          r_sop   <= 1'b0;
          r_eop   <= 1'b0;
          r_busy  <= 1'b0;
        end
      end else begin
        case (r_state)
`ifdef VST_PATTERN_CTRL_PKT_EN
          ST_CTRL: begin
            if (r_cidx == 4'(CTRL_BEATS - 1)) begin
              r_state <= ST_VHDR;
              r_data  <= DATA_WIDTH'(PKT_TYPE_VIDEO);
              r_sop   <= 1'b1;
              r_eop   <= 1'b0;
            end else begin
              r_cidx  <= r_cidx + 4'd1;
              r_data  <= DATA_WIDTH'(ctrl_nibble(r_cidx + 4'd1));
              r_sop   <= 1'b0;
              r_eop   <= (r_cidx + 4'd1) == 4'(CTRL_BEATS - 1);
            end
          end
`endif
          ST_VHDR, ST_PIXEL: begin
            r_state <= ST_PIXEL;
            r_data  <= w_pix;
            r_sop   <= 1'b0;
            r_eop   <= w_pix_last;
            // Raster advance; the bar index steps every IM_WIDTH/8 pixels.
            if (r_x == X_LAST) begin
              r_x       <= '0;
              r_bar     <= '0;
              r_bar_cnt <= '0;
              r_y       <= (r_y == Y_LAST) ? '0 : r_y + 16'd1;
            end else begin
              r_x <= r_x + 16'd1;
              if (r_bar_cnt == BAR_LEN_LAST) begin
                r_bar_cnt <= '0;
                r_bar     <= r_bar + 3'd1;
              end else begin
                r_bar_cnt <= r_bar_cnt + 16'd1;
              end
            end
          end
          default: begin
            r_state <= ST_IDLE;
            r_data  <= '0;
            r_valid <= 1'b0;
            r_sop   <= 1'b0;
            r_eop   <= 1'b0;
            r_busy  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign dout.dout_data          = r_data;
  assign dout.dout_valid         = r_valid;
  assign dout.dout_startofpacket = r_sop;
  assign dout.dout_endofpacket   = r_eop;
  assign frame_cnt               = r_frame_cnt;
  assign busy                    = r_busy;

endmodule

// File: tb/tb_vst_pal_pattern_gen.sv
// Self-checking bench for vst_pal_pattern_gen (16x2 frame, 10-bit beats).
// Expected beats come from a frame model built from the packet/pattern rules.
module tb_vst_pal_pattern_gen;

  localparam int DW = 10;
  localparam int W  = 16;
  localparam int H  = 2;
  localparam logic [9:0] FLAT = 10'd300;
`ifdef VST_PATTERN_CTRL_PKT_EN
  localparam int PRE = 11;
  localparam logic [9:0] FIRST_TYPE = 10'hF;
`else
  localparam int PRE = 1;
  localparam logic [9:0] FIRST_TYPE = 10'h0;
`endif
  localparam int L = PRE + W * H;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        enable = 1'b0;
  logic [1:0]  psel = 2'd0;
  logic [15:0] frame_cnt;
  logic        busy;

  vst_pal_pattern_gen_if #(.DATA_WIDTH(DW)) u_if ();

  vst_pal_pattern_gen #(
    .DATA_WIDTH   (DW),
    .IM_WIDTH     (W),
    .IM_HEIGHT    (H),
    .IM_INTERLACE (4'h0),
    .FLAT_LEVEL   (FLAT)
  ) dut (
    .vst_clk     (clk),
    .vst_rst     (rst),
    .enable      (enable),
    .pattern_sel (psel),
    .dout        (u_if),
    .frame_cnt   (frame_cnt),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  int n_xfer = 0;
  int exp_frames = 0;
  int bubbles = 0;
  bit watch_bubble = 1'b0;
  bit rnd_ready = 1'b0;
  logic [11:0] exp_q[$];   // {data, sop, eop}

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [9:0] ref_pix(input int mode, input int x, input int y);
    case (mode)
      0:       return 10'(((x / (W / 8)) * 1023) / 7);
      1:       return 10'(x % 1024);
      2:       return FLAT;
      default: return (((x / 32) % 2) != ((y / 32) % 2)) ? 10'd1023 : 10'd0;
    endcase
  endfunction

  task automatic push_frame(input int mode);
`ifdef VST_PATTERN_CTRL_PKT_EN
    exp_q.push_back({10'hF, 1'b1, 1'b0});
    for (int i = 0; i < 4; i++) exp_q.push_back({10'((W / (1 << (12 - 4 * i))) % 16), 2'b00});
    for (int i = 0; i < 4; i++) exp_q.push_back({10'((H / (1 << (12 - 4 * i))) % 16), 2'b00});
    exp_q.push_back({10'h0, 1'b0, 1'b1});
`endif
    exp_q.push_back({10'h0, 1'b1, 1'b0});
    for (int y = 0; y < H; y++)
      for (int x = 0; x < W; x++)
        exp_q.push_back({ref_pix(mode, x, y), 1'b0, (x == W - 1) && (y == H - 1)});
  endtask

  // Ready driver: always ready, or a coin toss per cycle.
  always @(posedge clk) begin
    #1;
    u_if.dout_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  // Monitor: scoreboard of transferred beats and hold-while-stalled check.
  logic [11:0] prev_beat = '0;
  bit          prev_stall = 1'b0;
  always @(negedge clk) begin
    if (rst) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall)
        chk("hold", 32'({u_if.dout_valid, u_if.dout_data, u_if.dout_startofpacket, u_if.dout_endofpacket}),
            32'({1'b1, prev_beat}));
      if (watch_bubble && !u_if.dout_valid) bubbles++;
      if (u_if.dout_valid && u_if.dout_ready) begin
        n_xfer++;
        if (exp_q.size() == 0) begin
          chk("extra_beat", 32'({1'b1, u_if.dout_data}), 32'h0);
        end else begin
          logic [11:0] e;
          e = exp_q.pop_front();
          chk($sformatf("beat%0d", n_xfer),
              32'({u_if.dout_data, u_if.dout_startofpacket, u_if.dout_endofpacket}), 32'(e));
          if (e[0]) exp_frames++;
        end
      end
      prev_stall = u_if.dout_valid && !u_if.dout_ready;
      prev_beat  = {u_if.dout_data, u_if.dout_startofpacket, u_if.dout_endofpacket};
    end
  end

  task automatic wait_xfer(input int target, input int budget);
    int c = 0;
    do begin
      @(posedge clk);
      c++;
    end while (n_xfer < target && c < budget);
    if (n_xfer < target) chk("timeout_xfer", 32'(n_xfer), 32'(target));
    #1;
  endtask

  task automatic wait_drain(input int budget);
    int c = 0;
    do begin
      @(posedge clk);
      c++;
    end while (exp_q.size() != 0 && c < budget);
    if (exp_q.size() != 0) chk("timeout_drain", 32'(exp_q.size()), 32'd0);
    #1;
  endtask

  task automatic chk_quiet(input string tag);
    chk({tag, "_valid"}, 32'(u_if.dout_valid), 32'd0);
    chk({tag, "_sop"}, 32'(u_if.dout_startofpacket), 32'd0);
    chk({tag, "_eop"}, 32'(u_if.dout_endofpacket), 32'd0);
    chk({tag, "_data"}, 32'(u_if.dout_data), 32'd0);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int modes[4];
    int base;
    int m;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk_quiet("rst");
    chk("rst_frame_cnt", 32'(frame_cnt), 32'd0);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Single bars frame, ready held high
    psel = 2'd0;
    push_frame(0);
    enable = 1'b1;
    @(posedge clk);
    #1;
    enable = 1'b0;
    wait_drain(200);
    repeat (2) @(posedge clk);
    #1;
    chk_quiet("bars_end");
    chk("bars_frame_cnt", 32'(frame_cnt), 32'(exp_frames));

    // Back-to-back frames, random ready, pattern_sel changed mid-frame
    rnd_ready = 1'b1;
    modes[0] = $urandom_range(0, 3);
    for (int f = 1; f < 4; f++) modes[f] = (modes[f - 1] + 1 + $urandom_range(0, 2)) % 4;
    for (int f = 0; f < 4; f++) push_frame(modes[f]);
    base = n_xfer;
    bubbles = 0;
    psel = 2'(modes[0]);
    enable = 1'b1;
    for (int f = 0; f < 4; f++) begin
      wait_xfer(base + f * L + 2, 400);
      watch_bubble = 1'b1;
      psel = 2'($urandom);
      wait_xfer(base + f * L + 20, 400);
      if (f < 3) begin
        psel = 2'(modes[f + 1]);
      end else begin
        enable = 1'b0;
        watch_bubble = 1'b0;
      end
    end
    wait_drain(600);
    rnd_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("b2b_bubbles", 32'(bubbles), 32'd0);
    chk_quiet("b2b_end");
    chk("b2b_frame_cnt", 32'(frame_cnt), 32'(exp_frames));

    // One-cycle enable pulse gives exactly one frame
    m = $urandom_range(0, 3);
    psel = 2'(m);
    push_frame(m);
    base = n_xfer;
    enable = 1'b1;
    @(posedge clk);
    #1;
    enable = 1'b0;
    psel = 2'($urandom);
    wait_drain(200);
    repeat (5) @(posedge clk);
    #1;
    chk("pulse_len", 32'(n_xfer - base), 32'(L));
    chk_quiet("pulse_end");
    chk("pulse_frame_cnt", 32'(frame_cnt), 32'(exp_frames));

    // Reset at pixel 5 aborts the packet; next frame restarts cleanly
    m = $urandom_range(0, 3);
    psel = 2'(m);
    push_frame(m);
    base = n_xfer;
    enable = 1'b1;
    wait_xfer(base + PRE + 5, 200);
    rst = 1'b1;
    #1;
    chk_quiet("midrst");
    chk("midrst_frame_cnt", 32'(frame_cnt), 32'd0);
    exp_q.delete();
    exp_frames = 0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    m = $urandom_range(0, 3);
    psel = 2'(m);
    push_frame(m);
    @(posedge clk);
    #1;
    enable = 1'b0;
    @(negedge clk);
    chk("post_rst_first", 32'({u_if.dout_valid, u_if.dout_startofpacket, u_if.dout_data}),
        32'({1'b1, 1'b1, FIRST_TYPE}));
    wait_drain(200);
    repeat (3) @(posedge clk);
    #1;
    chk_quiet("post_rst_end");
    chk("post_rst_frame_cnt", 32'(frame_cnt), 32'(exp_frames));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/vst_pal_pattern_gen.md
VST_PAL_PATTERN_GEN -- requirements
Module: vst_pal_pattern_gen

Interface
REQ-001 Parameter DATA_WIDTH, 10, beat width (at least 4).
REQ-002 Parameter IM_WIDTH, 720, active pixels per line (1..65535, multiple of 8).
REQ-003 Parameter IM_HEIGHT, 288, lines per packet (1..65535).
REQ-004 Parameter IM_INTERLACE, 4'h0, interlace nibble sent in the control packet.
REQ-005 Parameter FLAT_LEVEL, 10'd512, pixel value for flat mode.
REQ-006 vst_clk, input, 1: the single clock.
REQ-007 vst_rst, input, 1: asynchronous, active-high reset.
REQ-008 enable, input, 1: frame generation request.
REQ-009 pattern_sel, input, 2: 0 = bars, 1 = ramp, 2 = flat, 3 = checker.
REQ-010 dout_data, output, DATA_WIDTH: stream beat.
REQ-011 dout_valid, output, 1: beat valid.
REQ-012 dout_ready, input, 1: sink ready, ready latency 0.
REQ-013 dout_startofpacket, output, 1: first beat of a packet.
REQ-014 dout_endofpacket, output, 1: last beat of a packet.
REQ-015 frame_cnt, output, 16: count of completed video packets.
REQ-016 busy, output, 1: high in any state other than IDLE.

Function
REQ-017 A beat transfers on a rising edge where dout_valid and dout_ready are both 1.
- While valid is 1 and ready is 0, data, SOP and EOP SHALL hold stable.
REQ-018 The FSM SHALL have four states: IDLE, CTRL, VHDR and PIXEL.
REQ-019 IDLE -> CTRL (VHDR without the macro) on the first cycle enable is 1.
- pattern_sel is latched on that same cycle.
- pattern_sel is ignored at all other times.
REQ-020 CTRL SHALL emit 10 beats, with SOP on beat 0 and EOP on beat 9.
- Beat 0 is type nibble 4'hF.
- Beats 1-4 are the IM_WIDTH nibbles, MSB nibble first.
- Beats 5-8 are the IM_HEIGHT nibbles, MSB nibble first.
- Beat 9 is IM_INTERLACE.
- Every nibble sits in dout_data[3:0], with the upper bits 0.
REQ-021 VHDR SHALL emit one beat: type 4'h0, with SOP=1 and EOP=0.
REQ-022 PIXEL SHALL emit IM_WIDTH*IM_HEIGHT beats in raster order.
- Counter x runs 0..IM_WIDTH-1 and y runs 0..IM_HEIGHT-1.
- EOP=1 only when x=IM_WIDTH-1 and y=IM_HEIGHT-1.
REQ-023 Pixel value by mode:
- Bars: level k*(2^DATA_WIDTH-1)/7, where k = x/(IM_WIDTH/8).
- k is generated by a sub-counter; no divider.
- Ramp: x modulo 2^DATA_WIDTH.
- Flat: FLAT_LEVEL.
- Checker: all-ones if x[5]^y[5], else 0.
REQ-024 On the last pixel transfer, frame_cnt SHALL increment; it wraps at 16'hFFFF to 0.
- If enable=1 on that cycle: next state is CTRL (or VHDR without the macro) and pattern_sel is re-latched.
- If enable=0: next state is IDLE.
REQ-025 Deasserting enable mid-packet SHALL NOT truncate the packet; the current frame completes.
REQ-026 dout_valid SHALL be 1 in CTRL, VHDR and PIXEL, and 0 in IDLE.
- There are no bubbles between packets.
REQ-027 Outputs SHALL be registered, with a single output stage.

Reset
REQ-028 While vst_rst=1, all outputs SHALL be forced low.
- dout_valid, SOP, EOP, dout_data, busy and frame_cnt are all 0.
- The FSM is in IDLE.
- All counters are 0.
REQ-029 Reset asserted mid-packet SHALL abort that packet immediately.
- After reset the next packet starts from beat 0 with SOP.

Configuration
REQ-030 Macro VST_PATTERN_CTRL_PKT_EN.
- Defined: every frame is a CTRL packet followed by a video packet.
- Undefined: the CTRL state and its nibble logic are not compiled, and IDLE goes directly to VHDR.

Structure
REQ-031 The shared package vst_pkg SHALL hold:
- packet type constants (4'hF, 4'h0);
- the pattern_sel encodings;
- the FSM state typedef.
REQ-032 Pixel-value generation SHALL be one sub-module, vst_pattern_pixel.
- Inputs: x, y, bar index, latched mode.
- Output: pixel value (combinational).

Verification
Unless stated otherwise, the bench uses IM_WIDTH=16, IM_HEIGHT=2, DATA_WIDTH=10 and the macro defined.
REQ-033 enable=1, ready=1, mode 0 -> exact beat sequence:
- CTRL: F, 0, 0, 1, 0, 0, 0, 0, 2, 0;
- VHDR: 0;
- then 32 pixels with bar levels 0, 146, 292, ..., 1023, two pixels per bar;
- frame_cnt=1.
REQ-034 Random ready with about 50% duty -> the same beat sequence, with data/SOP/EOP stable whenever valid=1 and ready=0.
REQ-035 enable pulsed for 1 cycle -> exactly one CTRL+video pair, then IDLE and busy=0.
REQ-036 pattern_sel changed mid-frame -> the current frame is unchanged and the next frame uses the new mode.
REQ-037 vst_rst asserted at pixel 5 -> outputs are 0 immediately; after release with enable=1, the next beat is a CTRL beat 4'hF with SOP=1.
REQ-038 Macro undefined, mode 2, FLAT_LEVEL=300 -> VHDR beat 0 with SOP, then 32 beats of 300, EOP on beat 32.
